updown_count_sequencer: RTL and testbench
=========================================

Name: updown_count_sequencer

Overview:
Controller that runs the team's modulo up/down counter under command control. It accepts a run command with direction, modulus and wrap count over a valid/ready handshake. It then steps the count on each enabled tick and reports wrap events and completion. It sits between a host/config register block and any logic consuming the count value, such as display or timing strobes.

Parameters:
WIDTH, 4, count width in bits; legal modulus range is 2..2^WIDTH-1
WRAPW, 8, width of the wrap-target and wrap-counter fields

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset: synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command; high only in IDLE
cmd_dir  input  1  1 = count up, 0 = count down
cmd_mod  input  WIDTH  modulus M; count range 0..M-1
cmd_wraps  input  WRAPW  wrap target N; 0 = free-run until abort
tick  input  1  count enable strobe
hold  input  1  freeze counting while high
abort  input  1  terminate the current run
count  output  WIDTH  current count value
busy  output  1  high in RUN
wrap  output  1  one-cycle pulse on each modulus rollover
wrap_cnt  output  WRAPW  wraps completed in current run; saturates at 2^WRAPW-1
done  output  1  one-cycle pulse when wrap_cnt reaches N
err  output  1  one-cycle pulse when a command with an illegal modulus is rejected

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, count=0, wrap_cnt=0, busy=0, wrap=0, done=0, err=0, cmd_ready=1.
- States: IDLE, RUN, DONE.
- IDLE, command accept (cmd_valid & cmd_ready):
  - If cmd_mod<2: no accept, err=1 next cycle, stay IDLE.
  - Otherwise latch dir/M/N. On the next edge: count = dir ? 0 : M-1, wrap_cnt=0, state=RUN.
- RUN step condition: tick & ~hold & ~abort. Count updates on the edge where tick is sampled (1-cycle latency).
- RUN, up: count==M-1 -> count=0 and wrap=1; else count+1.
- RUN, down: count==0 -> count=M-1 and wrap=1; else count-1.
- On a wrap:
  - wrap_cnt increments, saturating.
  - If N!=0 and the new wrap_cnt==N: state=DONE. The count holds its wrapped value (0 up, M-1 down).
- DONE: done=1 for exactly one cycle, then IDLE. count and wrap_cnt hold until the next accept.
- abort in RUN: state=IDLE next edge. No step, no wrap, no done; count holds.
- abort in IDLE/DONE: ignored.
- Priority: reset > abort > hold > tick.
- hold high with tick: the tick is dropped, not queued.
- cmd_valid while busy: ignored (cmd_ready=0); the host must hold it until ready.
- The latched M/N/dir are immune to cmd_* changes during RUN.
- N=0: wrap_cnt saturates at max and the run continues until abort.
- M is an unsigned compare; no counting beyond M-1 is possible.
- reset mid-RUN: next edge yields full reset values; the run is lost, with no done pulse.

Decomposition:
- Package updown_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - DIR_UP=1, DIR_DOWN=0
  - MIN_MOD=2
- Sub-module mod_step (combinational):
  - inputs: count, M, dir
  - outputs: next_count, rollover
  - instantiated once; unit-testable exhaustively at WIDTH=4.

Test Plan:
- Reset then idle: cmd_ready=1, count=0, all pulses 0.
- Up run, cmd_dir=1, M=10, N=2, tick every cycle: count 0..9 then 0; wrap pulses on counts 9->0 twice. done pulses on the cycle after the 2nd wrap, with count=0, wrap_cnt=2; then cmd_ready=1.
- Down run, M=6, N=1: count starts 5 and steps 4,3,2,1,0,5. wrap=1 on 0->5, then done=1 and IDLE with count=5.
- hold/tick mix, M=10 up: hold high for 3 ticks, then release. Count frozen during hold and resumes +1 per tick; the dropped ticks are not replayed.
- Abort at count=7, M=10, N=0: busy falls next cycle, count stays 7, done never pulses. A new command is then accepted.
- Illegal M=1: err=1 one cycle, state stays IDLE, count unchanged. A following M=3 command counts 0,1,2,0.
- Reset asserted mid-RUN at count=4: next cycle count=0, busy=0, wrap_cnt=0.

Source files
------------

// File: rtl/updown_seq_pkg.sv
// Shared types and constants for the up/down count sequencer.
package updown_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic        DIR_UP   = 1'b1;
  localparam logic        DIR_DOWN = 1'b0;
  localparam int unsigned MIN_MOD  = 2;

endpackage

// File: rtl/updown_count_sequencer_mod_step.sv
// One modulo step of the counter: next value and rollover flag for a given direction.
module mod_step
  import updown_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] modulus,
  input  logic             dir,
  output logic [WIDTH-1:0] next_count,
  output logic             rollover
);

  logic [WIDTH-1:0] top_val;

  assign top_val = modulus - WIDTH'(1);

  always_comb begin
    next_count = count;
    rollover   = 1'b0;
    if (dir == DIR_UP) begin
      rollover   = (count == top_val);
      next_count = rollover ? '0 : count + WIDTH'(1);
    end else begin
      rollover   = (count == '0);
      next_count = rollover ? top_val : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_count_sequencer.sv
// Command-driven modulo up/down counter with wrap counting, completion and reject pulses.
module updown_count_sequencer
  import updown_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WRAPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_mod,
  input  logic [WRAPW-1:0] cmd_wraps,
  input  logic             tick,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             wrap,
  output logic [WRAPW-1:0] wrap_cnt,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WRAPW-1:0] n_q, n_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] step_count;
  logic             step_roll;
  logic [WRAPW-1:0] wrap_inc;

  mod_step #(.WIDTH(WIDTH)) u_step (
    .count      (count_q),
    .modulus    (mod_q),
    .dir        (dir_q),
    .next_count (step_count),
    .rollover   (step_roll)
  );

  assign wrap_inc = (wrap_cnt_q == '1) ? wrap_cnt_q : wrap_cnt_q + WRAPW'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wrap_cnt_d = wrap_cnt_q;
    mod_d      = mod_q;
    n_d        = n_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          if (cmd_mod < WIDTH'(MIN_MOD)) begin
            err_d = 1'b1;
          end else begin
            mod_d      = cmd_mod;
            n_d        = cmd_wraps;
            dir_d      = cmd_dir;
            count_d    = (cmd_dir == DIR_UP) ? '0 : cmd_mod - WIDTH'(1);
            wrap_cnt_d = '0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick && !hold) begin
          count_d = step_count;
          if (step_roll) begin
            wrap_d     = 1'b1;
            wrap_cnt_d = wrap_inc;
            if (n_q != '0 && wrap_inc == n_q) state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d  = (state_d == RUN);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wrap_cnt_q <= '0;
      mod_q      <= '0;
      n_q        <= '0;
      dir_q      <= DIR_UP;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wrap_cnt_q <= wrap_cnt_d;
      mod_q      <= mod_d;
      n_q        <= n_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign wrap_cnt  = wrap_cnt_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs, a monitor compares them.
module tb_updown_count_sequencer;

  localparam int W  = 4;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [W-1:0]  cmd_mod = '0;
  logic [WW-1:0] cmd_wraps = '0;
  logic          tick = 1'b0;
  logic          hold = 1'b0;
  logic          abort = 1'b0;
  logic          cmd_ready, busy, wrap, done, err;
  logic [W-1:0]  count;
  logic [WW-1:0] wrap_cnt;

  updown_count_sequencer #(.WIDTH(W), .WRAPW(WW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_mod   (cmd_mod),
    .cmd_wraps (cmd_wraps),
    .tick      (tick),
    .hold      (hold),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .wrap      (wrap),
    .wrap_cnt  (wrap_cnt),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ready;
    logic [W-1:0]  count;
    logic          busy;
    logic          wrap;
    logic [WW-1:0] wrap_cnt;
    logic          done;
    logic          err;
  } obs_t;

  obs_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: plain integers and flags, advanced once per rising edge.
  bit m_run = 0, m_donep = 0, m_dir = 0;
  int m_count = 0, m_mod = 2, m_n = 0, m_wc = 0;

  always @(posedge clk) begin : model
    obs_t e;
    bit   w, d, er;
    int   nc;
    w = 0; d = 0; er = 0;
    if (reset) begin
      m_run = 0; m_donep = 0; m_count = 0; m_wc = 0;
    end else if (m_donep) begin
      d = 1; m_donep = 0;
    end else if (m_run) begin
      if (abort) begin
        m_run = 0;
      end else if (tick && !hold) begin
        if (m_dir) begin
          nc = (m_count + 1) % m_mod;
          w  = (nc == 0);
        end else begin
          nc = (m_count + m_mod - 1) % m_mod;
          w  = (nc == m_mod - 1);
        end
        m_count = nc;
        if (w) begin
          if (m_wc < (1 << WW) - 1) m_wc = m_wc + 1;
          if (m_n != 0 && m_wc == m_n) begin
            m_run = 0; m_donep = 1;
          end
        end
      end
    end else if (cmd_valid) begin
      if (int'(cmd_mod) < 2) begin
        er = 1;
      end else begin
        m_dir = cmd_dir; m_mod = int'(cmd_mod); m_n = int'(cmd_wraps);
        m_count = m_dir ? 0 : m_mod - 1;
        m_wc = 0; m_run = 1;
      end
    end
    e.ready    = !m_run && !m_donep;
    e.count    = W'(m_count);
    e.busy     = m_run;
    e.wrap     = w;
    e.wrap_cnt = WW'(m_wc);
    e.done     = d;
    e.err      = er;
    expq.push_back(e);
  end

  always @(posedge clk) begin : monitor
    obs_t a, e;
    #1;
    a.ready = cmd_ready; a.count = count; a.busy = busy; a.wrap = wrap;
    a.wrap_cnt = wrap_cnt; a.done = done; a.err = err;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty at %0t: got %h, no expectation queued", $time, a);
    end else begin
      e = expq.pop_front();
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs at %0t: got rdy=%b cnt=%0d busy=%b wrap=%b wc=%0d done=%b err=%b, want rdy=%b cnt=%0d busy=%b wrap=%b wc=%0d done=%b err=%b",
                 $time, a.ready, a.count, a.busy, a.wrap, a.wrap_cnt, a.done, a.err,
                 e.ready, e.count, e.busy, e.wrap, e.wrap_cnt, e.done, e.err);
      end
    end
  end

  task automatic step(input logic v, input logic d, input logic [W-1:0] m,
                      input logic [WW-1:0] n, input logic t, input logic h,
                      input logic a, input logic r);
    cmd_valid = v; cmd_dir = d; cmd_mod = m; cmd_wraps = n;
    tick = t; hold = h; abort = a; reset = r;
    @(negedge clk);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Up, M=10, N=2
    step(1'b1, 1'b1, 4'd10, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(24);
    // Down, M=6, N=1
    step(1'b1, 1'b0, 4'd6, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(9);
    // Hold mixed with ticks, cmd_* changing during the run
    step(1'b1, 1'b1, 4'd10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd3, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    ticks(3);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Abort at count 7, then a new command
    step(1'b1, 1'b1, 4'd10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(7);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    // Illegal modulus, then M=3
    step(1'b1, 1'b1, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd3, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(6);
    // Reset mid-run at count 4
    step(1'b1, 1'b1, 4'd10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(4);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Wrap counter saturation with M=2, N=0; also the max modulus
    step(1'b1, 1'b1, 4'd2, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(530);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd15, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(34);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 250) == 0));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
